// File: rtl/uart_tx_sequencer.sv
// UART transmit sequencer: one start bit, DATA_BITS data bits LSB first, one stop bit per accepted byte.
// Latency: start bit appears on tx one cycle after the tx_valid/tx_ready handshake.
// Backpressure: tx_ready is high only in IDLE; tx_valid is ignored while a frame is in flight.
module uart_tx_sequencer #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(DATA_BITS);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t               state, state_nxt;
    logic [BW-1:0]        baud, baud_nxt;
    logic [CW-1:0]        bitc, bitc_nxt;
    logic [DATA_BITS-1:0] shift, shift_nxt;
    logic                 tx_nxt, done_nxt;
    logic                 bit_end;

    assign bit_end  = (baud == BAUD_LAST);
    assign tx_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            baud  <= '0;
            bitc  <= '0;
            shift <= '0;
            tx    <= 1'b1;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            baud  <= baud_nxt;
            bitc  <= bitc_nxt;
            shift <= shift_nxt;
            tx    <= tx_nxt;
            done  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        bitc_nxt  = bitc;
        shift_nxt = shift;
        tx_nxt    = tx;
        done_nxt  = 1'b0;
        // Baud counter free-runs in every frame state and rests at zero in IDLE.
        if (state == IDLE || bit_end) begin
            baud_nxt = '0;
        end else begin
            baud_nxt = baud + BW'(1);
        end

        case (state)
            IDLE: begin
                tx_nxt = 1'b1;
                if (tx_valid) begin
                    shift_nxt = tx_data;
                    state_nxt = START;
                    tx_nxt    = 1'b0;
                end
            end
            START: begin
                tx_nxt = 1'b0;
                if (bit_end) begin
                    state_nxt = DATA;
                    tx_nxt    = shift[0];
                end
            end
            DATA: begin
                tx_nxt = shift[0];
                if (bit_end) begin
                    shift_nxt = shift >> 1;
                    if (bitc == BIT_LAST) begin
                        state_nxt = STOP;
                        bitc_nxt  = '0;
                        tx_nxt    = 1'b1;
                    end else begin
                        bitc_nxt = bitc + CW'(1);
                        tx_nxt   = shift[1];
                    end
                end
            end
            STOP: begin
                tx_nxt = 1'b1;
                if (bit_end) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                tx_nxt    = 1'b1;
            end
        endcase
    end

endmodule

// File: doc/uart_tx_sequencer.md
Name: uart_tx_sequencer

Overview:
- Controller for the UART transmit path. Sequences two internal counters: a baud-period counter and a bit-index counter.
- Uses those counters to drive one serial frame per accepted byte: a start bit, DATA_BITS data bits sent LSB first, then one stop bit.
- Sits between the FIR output stage (valid/ready byte source) and the FPGA TX pin.
- Asserts `busy` while a frame is on the line and pulses `done` when the frame ends.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per serial bit (100 MHz / 115200). Legal range ≥ 2.
- DATA_BITS, 8, data bits per frame. Legal range 5..9.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- tx_valid  input  1  byte source has data on tx_data.
- tx_data  input  DATA_BITS  byte to send; sampled only on acceptance.
- tx_ready  output  1  sequencer can accept a byte (combinational: state==IDLE).
- tx  output  1  serial line, registered; idles high.
- busy  output  1  high in START, DATA and STOP states (registered state decode).
- done  output  1  one-cycle pulse, registered, when the stop bit completes.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE, tx=1, done=0, baud counter=0, bit counter=0, shift register=0.
  - Reset takes precedence over every other event, including mid-frame: the line returns high on that edge and the partial frame is abandoned with no done pulse.
  - tx_valid is ignored in any cycle where rst=1.
- Counters:
  - Baud counter width = $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 in every non-IDLE state.
  - bit_end is true when the baud counter = CLKS_PER_BIT-1. On bit_end the counter wraps to 0.
  - Bit counter width = $clog2(DATA_BITS). It counts 0..DATA_BITS-1 and advances only on bit_end in DATA.
- States and transitions:
  - IDLE: tx=1, tx_ready=1.
    - On tx_valid & tx_ready: latch tx_data into the shift register, go to START, tx=0 from the next edge.
    - Latency from acceptance to the start bit on the line is exactly 1 cycle.
  - START: tx=0 for CLKS_PER_BIT cycles. On bit_end go to DATA; tx=shift[0].
  - DATA: tx=current LSB.
    - On bit_end: shift right by 1 and increment the bit counter.
    - If bit counter = DATA_BITS-1 at bit_end, go to STOP with tx=1 and the bit counter cleared.
  - STOP: tx=1 for CLKS_PER_BIT cycles. On bit_end go to IDLE and set done=1 for exactly one cycle.
- Frame timing: the tx frame occupies (DATA_BITS+2)*CLKS_PER_BIT cycles, starting with the first low cycle.
- Handshake rules:
  - tx_valid while not IDLE is ignored; tx_ready=0 applies backpressure.
  - tx_data changes after acceptance do not affect the frame in flight.
  - tx_valid is not required to stay high after acceptance.
- Back-to-back frames:
  - The first IDLE cycle (the one where done=1) already has tx_ready=1.
  - If tx_valid is held, the next byte is accepted in that cycle, giving exactly 1 idle-high cycle between the stop bit and the next start bit.
- done and busy:
  - done and the tx_ready of the first IDLE cycle coincide.
  - busy falls in the same cycle done rises.
- No other outputs change while in IDLE.

Test Plan (CLKS_PER_BIT=4, DATA_BITS=8 unless stated):
- Reset then idle: hold rst=1 for 3 cycles, release, tx_valid=0 for 20 cycles -> tx=1, busy=0, done=0, tx_ready=1 throughout.
- Single frame: accept 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each value held 4 cycles. The first 0 appears 1 cycle after acceptance and the frame lasts 40 cycles. done=1 for 1 cycle at frame end; busy=1 for exactly 40 cycles.
- Back-to-back: hold tx_valid=1 with 0x00 then 0xFF -> after frame 1's done cycle, exactly 1 tx=1 cycle, then the second frame (0, eight 1s, 1). Two done pulses, 41 cycles apart.
- Ignored inputs: during a 0x3C frame, toggle tx_data randomly and pulse tx_valid in DATA -> transmitted bits are still 0x3C LSB-first; no extra frame; tx_ready=0 during the frame.
- Reset mid-frame: assert rst for 1 cycle during data bit 3 of 0x81 -> tx=1 on the next edge, no done pulse, tx_ready=1. A new 0x55 accepted afterwards transmits a correct full frame.
- Parameter corners: CLKS_PER_BIT=2, DATA_BITS=5, send 0x15 -> 14-cycle frame 0,1,0,1,0,1,1 (2 cycles each), done at cycle 14.
